disp_rx: RTL and testbench

// - Receive end of the TLC59282 LED-driver serial link (disp_sclk/disp_sin/disp_lat/disp_blank).
// - Oversamples the four pins in the clk domain, rebuilds the latched segment frame and flags

---
 rtl/disp_rx_pkg.sv | 17 +
 rtl/disp_rx_sync.sv | 36 +++
 rtl/disp_rx.sv | 156 +++++++++++++++
 tb/tb_disp_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_rx_pkg.sv
// Shared constants for the TLC59282 display-link receiver.
// Pure definitions: no logic, no latency, no flow control.
package disp_rx_pkg;

  localparam int DISP_FRAME_BITS = 256;
  localparam int DISP_MS_US      = 1000;
  localparam int DISP_STALE_MS   = 1000;
  localparam int DISP_LIT_W      = 10;

  // Bit positions of the four link pins inside the synchronizer vector.
  localparam int PIN_SCLK  = 0;
  localparam int PIN_SIN   = 1;
  localparam int PIN_LAT   = 2;
  localparam int PIN_BLANK = 3;
  localparam int PIN_N     = 4;

endpackage

// File: rtl/disp_rx_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for W asynchronous pins.
// rise fires 3 clk after a pin toggle; level_sync is aligned with rise; no backpressure.
module disp_rx_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin,
  output logic [W-1:0] level_sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_dly;
  logic [W-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_dly  <= '0;
      r_rise <= '0;
    end else begin
      r_meta <= pin;
      r_sync <= r_meta;
      r_dly  <= r_sync;
      r_rise <= r_sync & ~r_dly;
    end
  end

  // r_dly lines up with r_rise so data sampled on an edge keeps its pin setup.
  assign level_sync = r_dly;
  assign rise       = r_rise;

endmodule

// File: rtl/disp_rx.sv
// TLC59282 link receiver: rebuilds latched frames, measures lit time, flags stale display.
// lat pin rise -> frame_vld/frame_err in 4 clk; pulse/level outputs, no backpressure.
module disp_rx
  import disp_rx_pkg::*;
#(
  parameter int FRAME_BITS = DISP_FRAME_BITS,
  parameter int CNT_W      = 9,
  parameter int STALE_MS   = DISP_STALE_MS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tsc_1ppms,
  input  logic                  tsc_1ppus,
  input  logic                  rx_sclk,
  input  logic                  rx_sin,
  input  logic                  rx_lat,
  input  logic                  rx_blank,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_vld,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      err_bits,
  output logic [DISP_LIT_W-1:0] lit_us,
  output logic                  lit_vld,
  output logic                  stale
);

  localparam int MS_W = $clog2(STALE_MS + 1);
  localparam logic [CNT_W-1:0]      C_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]      C_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [MS_W-1:0]       C_STALE  = MS_W'(STALE_MS);
  localparam logic [DISP_LIT_W-1:0] C_US_MAX = '1;

  logic [PIN_N-1:0] w_pins;
  logic [PIN_N-1:0] w_level;
  logic [PIN_N-1:0] w_rise;
  logic             w_sclk_rise;
  logic             w_lat_rise;
  logic             w_sin;
  logic             w_blank;
  logic             w_unused;

  assign w_pins = {rx_blank, rx_lat, rx_sin, rx_sclk};

  disp_rx_sync #(
    .W (PIN_N)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .pin        (w_pins),
    .level_sync (w_level),
    .rise       (w_rise)
  );

  assign w_sclk_rise = w_rise[PIN_SCLK];
  assign w_lat_rise  = w_rise[PIN_LAT];
  assign w_sin       = w_level[PIN_SIN];
  assign w_blank     = w_level[PIN_BLANK];
  assign w_unused    = &{1'b0, w_level[PIN_SCLK], w_level[PIN_LAT],
                         w_rise[PIN_SIN], w_rise[PIN_BLANK]};

  logic [FRAME_BITS-1:0] r_sr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_frame_data;
  logic                  r_frame_vld;
  logic                  r_frame_err;
  logic [CNT_W-1:0]      r_err_bits;
  logic [DISP_LIT_W-1:0] r_us_cnt;
  logic [DISP_LIT_W-1:0] r_lit_us;
  logic                  r_lit_vld;
  logic [MS_W-1:0]       r_ms_cnt;

  logic [FRAME_BITS-1:0] w_sr_shift;
  logic [CNT_W-1:0]      w_cnt_shift;
  logic                  w_good;
  logic                  w_us_inc;
  logic [DISP_LIT_W-1:0] w_us_next;

  // The shift is resolved before the latch so a coincident sclk bit joins the frame.
  always_comb begin
    w_sr_shift  = r_sr;
    w_cnt_shift = r_bit_cnt;
    if (w_sclk_rise) begin
      w_sr_shift = {r_sr[FRAME_BITS-2:0], w_sin};
      if (r_bit_cnt != C_SAT) begin
        w_cnt_shift = r_bit_cnt + 1'b1;
      end
    end
    w_good   = w_lat_rise && (w_cnt_shift == C_FULL);
    w_us_inc = tsc_1ppus && !w_blank;
    w_us_next = r_us_cnt;
    if (w_us_inc && (r_us_cnt != C_US_MAX)) begin
      w_us_next = r_us_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_frame_data <= '0;
      r_frame_vld  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_bits   <= '0;
    end else begin
      r_sr        <= w_sr_shift;
      r_frame_vld <= w_good;
      r_frame_err <= w_lat_rise && !w_good;
      if (w_lat_rise) begin
        r_bit_cnt <= '0;
        if (w_good) begin
          r_frame_data <= w_sr_shift;
        end else begin
          r_err_bits <= w_cnt_shift;
        end
      end else begin
        r_bit_cnt <= w_cnt_shift;
      end
    end
  end

  // A us strobe coincident with the ms strobe counts in the report and seeds the next ms.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_us_cnt  <= '0;
      r_lit_us  <= '0;
      r_lit_vld <= 1'b0;
    end else begin
      r_lit_vld <= tsc_1ppms;
      if (tsc_1ppms) begin
        r_lit_us <= w_us_next;
        r_us_cnt <= DISP_LIT_W'(w_us_inc);
      end else begin
        r_us_cnt <= w_us_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms_cnt <= '0;
    end else if (w_good) begin
      r_ms_cnt <= '0;
    end else if (tsc_1ppms && (r_ms_cnt != C_STALE)) begin
      r_ms_cnt <= r_ms_cnt + 1'b1;
    end
  end

  assign frame_data = r_frame_data;
  assign frame_vld  = r_frame_vld;
  assign frame_err  = r_frame_err;
  assign err_bits   = r_err_bits;
  assign lit_us     = r_lit_us;
  assign lit_vld    = r_lit_vld;
  assign stale      = (r_ms_cnt == C_STALE);

endmodule

// File: tb/tb_disp_rx.sv
// Randomized scoreboard bench for disp_rx: a bit-list frame model, us/ms counters and a
// stale counter feed expectation queues that a negedge monitor pops on each output pulse.
module tb_disp_rx;
  import disp_rx_pkg::*;

  localparam int FB  = 256;
  localparam int CW  = 9;
  localparam int SMS = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          tsc_1ppms, tsc_1ppus;
  logic          rx_sclk, rx_sin, rx_lat, rx_blank;
  logic [FB-1:0] frame_data;
  logic          frame_vld, frame_err;
  logic [CW-1:0] err_bits;
  logic [9:0]    lit_us;
  logic          lit_vld, stale;

  disp_rx dut (
    .clk        (clk),
    .rst        (rst),
    .tsc_1ppms  (tsc_1ppms),
    .tsc_1ppus  (tsc_1ppus),
    .rx_sclk    (rx_sclk),
    .rx_sin     (rx_sin),
    .rx_lat     (rx_lat),
    .rx_blank   (rx_blank),
    .frame_data (frame_data),
    .frame_vld  (frame_vld),
    .frame_err  (frame_err),
    .err_bits   (err_bits),
    .lit_us     (lit_us),
    .lit_vld    (lit_vld),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [FB-1:0] q_frame[$];
  int            q_err[$];
  int            q_lit[$];
  bit            bits[$];
  int            us_m;
  int            ms_m;
  logic [FB-1:0] last_good;

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame rule: exactly FB bits since the last lat is a good frame, first bit lands in the MSB.
  task automatic model_lat();
    int n;
    logic [FB-1:0] d;
    n = bits.size();
    if (n == FB) begin
      for (int i = 0; i < FB; i++) d[FB-1-i] = bits[i];
      q_frame.push_back(d);
      ms_m = 0;
    end else begin
      q_err.push_back((n > FB + 1) ? FB + 1 : n);
    end
    bits.delete();
  endtask

  task automatic sclk_bit(input bit b, input bit with_lat);
    rx_sin = b;
    tick(2);
    rx_sclk = 1'b1;
    bits.push_back(b);
    if (with_lat) begin
      rx_lat = 1'b1;
      model_lat();
    end
    tick(3);
    rx_sclk = 1'b0;
    rx_lat  = 1'b0;
    tick(3);
    if (with_lat) tick(4);
  endtask

  task automatic lat_pulse();
    rx_lat = 1'b1;
    model_lat();
    tick(4);
    rx_lat = 1'b0;
    tick(6);
  endtask

  task automatic send_random(input int n, input bit coincide);
    for (int i = 0; i < n; i++) sclk_bit(1'($urandom), coincide && (i == n - 1));
    if (!coincide || n == 0) lat_pulse();
  endtask

  task automatic check_reset_outputs();
    chk("rst_frame_data", frame_data, '0);
    chk("rst_frame_vld", FB'(frame_vld), '0);
    chk("rst_frame_err", FB'(frame_err), '0);
    chk("rst_err_bits", FB'(err_bits), '0);
    chk("rst_lit_us", FB'(lit_us), '0);
    chk("rst_lit_vld", FB'(lit_vld), '0);
    chk("rst_stale", FB'(stale), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_sclk = 1'b0; rx_sin = 1'b0; rx_lat = 1'b0; rx_blank = 1'b0;
    tsc_1ppms = 1'b0; tsc_1ppus = 1'b0;
    tick(3);
    check_reset_outputs();
    bits.delete();
    us_m = 0;
    ms_m = 0;
    last_good = '0;
    rst = 1'b0;
    tick(4);
  endtask

  // One microsecond slot: blank settles well before the us strobe is sampled.
  task automatic us_step(input bit lit, input bit with_ms);
    int inc;
    rx_blank = !lit;
    tick(4);
    inc = lit ? 1 : 0;
    tsc_1ppus = 1'b1;
    if (with_ms) begin
      tsc_1ppms = 1'b1;
      q_lit.push_back((us_m + inc > 1023) ? 1023 : us_m + inc);
      us_m = inc;
      ms_m = (ms_m < SMS) ? ms_m + 1 : SMS;
    end else begin
      us_m = (us_m + inc > 1023) ? 1023 : us_m + inc;
    end
    tick(1);
    tsc_1ppus = 1'b0;
    tsc_1ppms = 1'b0;
  endtask

  task automatic ms_only();
    tsc_1ppms = 1'b1;
    q_lit.push_back(us_m);
    us_m = 0;
    ms_m = (ms_m < SMS) ? ms_m + 1 : SMS;
    tick(1);
    tsc_1ppms = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [FB-1:0] d;
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_vld) begin
          if (q_frame.size() == 0) chk("frame_vld_unexpected", FB'(frame_vld), '0);
          else begin
            d = q_frame.pop_front();
            chk("frame_data", frame_data, d);
            last_good = d;
          end
        end
        if (frame_err) begin
          if (q_err.size() == 0) chk("frame_err_unexpected", FB'(frame_err), '0);
          else begin
            e = q_err.pop_front();
            chk("err_bits", FB'(err_bits), FB'(e));
            chk("frame_data_hold", frame_data, last_good);
          end
        end
        if (lit_vld) begin
          if (q_lit.size() == 0) chk("lit_vld_unexpected", FB'(lit_vld), '0);
          else chk("lit_us", FB'(lit_us), FB'(q_lit.pop_front()));
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int n;
    bit co;
    pat = 8'hA5;
    last_good = '0;
    do_reset();

    for (int i = 0; i < FB; i++) sclk_bit(pat[7 - (i % 8)], 1'b0);
    lat_pulse();
    chk("a5_frame", frame_data, {32{8'hA5}});

    send_random(FB - 1, 1'b0);
    send_random(300, 1'b0);
    send_random(FB, 1'b1);

    for (int k = 0; k < 4; k++) begin
      n  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 300) : FB;
      co = 1'($urandom);
      send_random(n, co);
    end

    for (int i = 0; i < 100; i++) sclk_bit(1'($urandom), 1'b0);
    do_reset();
    send_random(FB, 1'b0);

    ms_only();
    for (int m = 0; m < 2; m++) begin
      for (int u = 0; u < DISP_MS_US; u++) us_step(u < 250, 1'b0);
      ms_only();
    end
    for (int u = 0; u < DISP_MS_US; u++) us_step(1'b1, 1'b0);
    ms_only();
    for (int m = 0; m < 4; m++) begin
      n  = $urandom_range(10, 40);
      co = 1'($urandom);
      for (int u = 0; u < n; u++) us_step(1'($urandom), co && (u == n - 1));
      if (!co) ms_only();
    end

    send_random(FB, 1'b0);
    chk("stale_after_good", FB'(stale), '0);
    for (int m = 0; m < SMS + 3; m++) begin
      ms_only();
      chk("stale_count", FB'(stale), FB'(ms_m == SMS));
    end
    send_random(10, 1'b0);
    chk("stale_after_bad", FB'(stale), FB'(1));
    send_random(FB, 1'b0);
    chk("stale_cleared", FB'(stale), '0);

    tick(20);
    chk("frame_q_drained", FB'(q_frame.size()), '0);
    chk("err_q_drained", FB'(q_err.size()), '0);
    chk("lit_q_drained", FB'(q_lit.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
